// File: rtl/pong_pkg.sv
// Shared constants and the digit-window mapping used by the score display.
// Windows are 64x64 and address the ROM as {row, col}.
package pong_pkg;

  localparam int DIGIT_W = 64;
  localparam int DIGIT_H = 64;
  localparam int ROM_AW  = 12;
  localparam int PIX_W   = 3;
  localparam int COORD_W = 10;
  localparam int OFF_W   = 6;

  typedef struct packed {
    logic              hit;
    logic [ROM_AW-1:0] addr;
  } win_t;

  // Offsets are one bit wider than a coordinate so a pixel left of or
  // above the origin wraps to a large value and fails the size test.
  function automatic win_t win_map(
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py,
    input logic [COORD_W-1:0] x0,
    input logic [COORD_W-1:0] y0
  );
    win_t w;
    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    dx = {1'b0, px} - {1'b0, x0};
    dy = {1'b0, py} - {1'b0, y0};
    w.hit = (dx < (COORD_W+1)'(DIGIT_W))
         && (dy < (COORD_W+1)'(DIGIT_H));
    w.addr = w.hit ? {dy[OFF_W-1:0], dx[OFF_W-1:0]} : '0;
    return w;
  endfunction

endpackage

// File: rtl/score_counter.sv
// Saturating 4-bit score counter; clear wins over inc.
// at_max is combinational from the stored count.
module score_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clear,
  input  logic [3:0] max,
  output logic [3:0] count,
  output logic       at_max
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  assign at_max = (count_q == max);
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/score_display_reader.sv
// Score counters, per-frame score snapshot and a two-stage pixel
// pipeline that reads the digit ROM for two on-screen windows.
module score_display_reader
  import pong_pkg::*;
#(
  parameter int LEFT_X    = 192,
  parameter int RIGHT_X   = 384,
  parameter int TOP_Y     = 32,
  parameter int MAX_SCORE = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic               score_left_inc,
  input  logic               score_right_inc,
  input  logic               score_clear,
  output logic [3:0]         rom_digit,
  output logic [11:0]        rom_addr,
  input  logic [2:0]         rom_data,
  output logic               pix_out_valid,
  output logic               pix_out_hit,
  output logic [2:0]         pix_out_rgb,
  output logic [3:0]         score_left,
  output logic [3:0]         score_right,
  output logic               game_over
);

  if ((LEFT_X + DIGIT_W > RIGHT_X) || (MAX_SCORE < 1)
      || (MAX_SCORE > 9)) begin : g_param_check
    $fatal(1, "score_display_reader: bad window or score params");
  end

  localparam logic [3:0] MAX_V = 4'(MAX_SCORE);

  logic       left_at_max;
  logic       right_at_max;
  logic       game_over_q;
  logic       game_over_d;
  logic [3:0] shadow_left_q;
  logic [3:0] shadow_left_d;
  logic [3:0] shadow_right_q;
  logic [3:0] shadow_right_d;

  logic              s1_valid_q;
  logic              s1_valid_d;
  logic              s1_hit_q;
  logic              s1_hit_d;
  logic [3:0]        rom_digit_q;
  logic [3:0]        rom_digit_d;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [ROM_AW-1:0] rom_addr_d;

  logic             out_valid_q;
  logic             out_valid_d;
  logic             out_hit_q;
  logic             out_hit_d;
  logic [PIX_W-1:0] out_rgb_q;
  logic [PIX_W-1:0] out_rgb_d;

  win_t win_l;
  win_t win_r;

  score_counter u_left (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (score_left_inc & ~game_over_q),
    .clear  (score_clear),
    .max    (MAX_V),
    .count  (score_left),
    .at_max (left_at_max)
  );

  score_counter u_right (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (score_right_inc & ~game_over_q),
    .clear  (score_clear),
    .max    (MAX_V),
    .count  (score_right),
    .at_max (right_at_max)
  );

  always_comb begin
    game_over_d = score_clear ? 1'b0
                : (game_over_q | left_at_max | right_at_max);
    shadow_left_d  = frame_start ? score_left  : shadow_left_q;
    shadow_right_d = frame_start ? score_right : shadow_right_q;
  end

  always_comb begin
    win_l = win_map(pix_x, pix_y,
                    COORD_W'(LEFT_X), COORD_W'(TOP_Y));
    win_r = win_map(pix_x, pix_y,
                    COORD_W'(RIGHT_X), COORD_W'(TOP_Y));
    s1_valid_d  = pix_valid;
    s1_hit_d    = 1'b0;
    rom_digit_d = '0;
    rom_addr_d  = '0;
    if (pix_valid && win_l.hit) begin
      s1_hit_d    = 1'b1;
      rom_digit_d = shadow_left_q;
      rom_addr_d  = win_l.addr;
    end else if (pix_valid && win_r.hit) begin
      s1_hit_d    = 1'b1;
      rom_digit_d = shadow_right_q;
      rom_addr_d  = win_r.addr;
    end
  end

  always_comb begin
    out_valid_d = s1_valid_q;
    out_hit_d   = s1_hit_q;
    out_rgb_d   = s1_hit_q ? rom_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_over_q    <= 1'b0;
      shadow_left_q  <= '0;
      shadow_right_q <= '0;
      s1_valid_q     <= 1'b0;
      s1_hit_q       <= 1'b0;
      rom_digit_q    <= '0;
      rom_addr_q     <= '0;
      out_valid_q    <= 1'b0;
      out_hit_q      <= 1'b0;
      out_rgb_q      <= '0;
    end else begin
      game_over_q    <= game_over_d;
      shadow_left_q  <= shadow_left_d;
      shadow_right_q <= shadow_right_d;
      s1_valid_q     <= s1_valid_d;
      s1_hit_q       <= s1_hit_d;
      rom_digit_q    <= rom_digit_d;
      rom_addr_q     <= rom_addr_d;
      out_valid_q    <= out_valid_d;
      out_hit_q      <= out_hit_d;
      out_rgb_q      <= out_rgb_d;
    end
  end

  assign rom_digit     = rom_digit_q;
  assign rom_addr      = rom_addr_q;
  assign pix_out_valid = out_valid_q;
  assign pix_out_hit   = out_hit_q;
  assign pix_out_rgb   = out_rgb_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_score_display_reader.sv
// Bench for score_display_reader: directed scenarios plus a random
// pixel/score stream checked against a behavioural model.
module tb_score_display_reader;

  localparam int LX = 192;
  localparam int RX = 384;
  localparam int TY = 32;
  localparam int MS = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        score_left_inc = 1'b0;
  logic        score_right_inc = 1'b0;
  logic        score_clear = 1'b0;
  logic [3:0]  rom_digit;
  logic [11:0] rom_addr;
  logic [2:0]  rom_data;
  logic        pix_out_valid;
  logic        pix_out_hit;
  logic [2:0]  pix_out_rgb;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic        game_over;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int m_l, m_r, m_go, sh_l, sh_r;
  int e1_v, e1_h, e1_d, e1_a;
  int e2_v, e2_h, e2_rgb;

  always #5 clk = ~clk;

  function automatic logic [2:0] rom_fn(input logic [3:0] d,
                                        input logic [11:0] a);
    int v;
    v = int'(d) * 5 + int'(a[11:6]) * 3 + int'(a[5:0]) + 1;
    return 3'(v);
  endfunction

  assign rom_data = rom_fn(rom_digit, rom_addr);

  score_display_reader #(
    .LEFT_X(LX), .RIGHT_X(RX), .TOP_Y(TY), .MAX_SCORE(MS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_valid       (pix_valid),
    .frame_start     (frame_start),
    .score_left_inc  (score_left_inc),
    .score_right_inc (score_right_inc),
    .score_clear     (score_clear),
    .rom_digit       (rom_digit),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .pix_out_valid   (pix_out_valid),
    .pix_out_hit     (pix_out_hit),
    .pix_out_rgb     (pix_out_rgb),
    .score_left      (score_left),
    .score_right     (score_right),
    .game_over       (game_over)
  );

  task automatic model_reset();
    m_l = 0; m_r = 0; m_go = 0; sh_l = 0; sh_r = 0;
    e1_v = 0; e1_h = 0; e1_d = 0; e1_a = 0;
    e2_v = 0; e2_h = 0; e2_rgb = 0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle.
  task automatic step(input int x, input int y, input bit pv,
                      input bit fs, input bit li, input bit ri,
                      input bit clr);
    int nx_go;
    pix_x = 10'(x); pix_y = 10'(y); pix_valid = pv;
    frame_start = fs; score_left_inc = li;
    score_right_inc = ri; score_clear = clr;
    @(posedge clk);
    e2_v = e1_v; e2_h = e1_h;
    e2_rgb = e1_h ? int'(rom_fn(4'(e1_d), 12'(e1_a))) : 0;
    e1_v = pv; e1_h = 0; e1_d = 0; e1_a = 0;
    if (pv && x >= LX && x < LX + 64 && y >= TY && y < TY + 64) begin
      e1_h = 1; e1_d = sh_l; e1_a = (y - TY) * 64 + (x - LX);
    end else if (pv && x >= RX && x < RX + 64
                 && y >= TY && y < TY + 64) begin
      e1_h = 1; e1_d = sh_r; e1_a = (y - TY) * 64 + (x - RX);
    end
    if (fs) begin sh_l = m_l; sh_r = m_r; end
    if (clr) begin
      m_l = 0; m_r = 0; m_go = 0;
    end else begin
      nx_go = (m_go != 0 || m_l == MS || m_r == MS) ? 1 : 0;
      if (m_go == 0) begin
        if (li && m_l < MS) m_l++;
        if (ri && m_r < MS) m_r++;
      end
      m_go = nx_go;
    end
    #1;
    pix_valid = 1'b0; frame_start = 1'b0; score_left_inc = 1'b0;
    score_right_inc = 1'b0; score_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #23;
    checks += 7;
    if (rom_digit !== 4'd0) begin errors++;
      $display("FAIL reset_digit got=%0d exp=0", rom_digit); end
    if (rom_addr !== 12'd0) begin errors++;
      $display("FAIL reset_addr got=%0h exp=0", rom_addr); end
    if (pix_out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%b exp=0", pix_out_valid); end
    if (pix_out_hit !== 1'b0) begin errors++;
      $display("FAIL reset_hit got=%b exp=0", pix_out_hit); end
    if (pix_out_rgb !== 3'd0) begin errors++;
      $display("FAIL reset_rgb got=%0d exp=0", pix_out_rgb); end
    if ({score_left, score_right} !== 8'd0) begin errors++;
      $display("FAIL reset_scores got=%0d/%0d exp=0/0",
               score_left, score_right); end
    if (game_over !== 1'b0) begin errors++;
      $display("FAIL reset_go got=%b exp=0", game_over); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_boundaries();
    int bx[15] = '{192, 255, 256, 191, 200, 200, 200, 384,
                   447, 448, 420, 300, 200, 0, 0};
    int by[15] = '{32, 95, 95, 40, 31, 96, 95, 32,
                   95, 60, 96, 60, 40, 0, 0};
    bit bv[15] = '{1, 1, 1, 1, 1, 1, 1, 1,
                   1, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      step(bx[i], by[i], bv[i], 0, 0, 0, 0);
      checks += 5;
      if (rom_digit !== 4'(e1_d)) begin errors++;
        $display("FAIL bnd_digit i=%0d got=%0d exp=%0d", i, rom_digit, e1_d); end
      if (rom_addr !== 12'(e1_a)) begin errors++;
        $display("FAIL bnd_addr i=%0d got=%0h exp=%0h", i, rom_addr, e1_a); end
      if (pix_out_valid !== 1'(e2_v)) begin errors++;
        $display("FAIL bnd_valid i=%0d got=%b exp=%0d", i, pix_out_valid, e2_v); end
      if (pix_out_hit !== 1'(e2_h)) begin errors++;
        $display("FAIL bnd_hit i=%0d got=%b exp=%0d", i, pix_out_hit, e2_h); end
      if (pix_out_rgb !== 3'(e2_rgb)) begin errors++;
        $display("FAIL bnd_rgb i=%0d got=%0d exp=%0d", i, pix_out_rgb, e2_rgb); end
      if (i == 0) begin checks++;
        if (rom_addr !== 12'h000) begin errors++;
          $display("FAIL origin_addr got=%0h exp=000", rom_addr); end
      end
      if (i == 1) begin checks += 2;
        if (rom_addr !== 12'hFFF) begin errors++;
          $display("FAIL corner_addr got=%0h exp=fff", rom_addr); end
        if (pix_out_hit !== 1'b1 || pix_out_rgb !== 3'd1) begin errors++;
          $display("FAIL origin_out got=%b/%0d exp=1/1",
                   pix_out_hit, pix_out_rgb); end
      end
      if (i == 3) begin checks++;
        if (pix_out_hit !== 1'b0 || pix_out_rgb !== 3'd0) begin errors++;
          $display("FAIL x_edge_miss got=%b/%0d exp=0/0",
                   pix_out_hit, pix_out_rgb); end
      end
    end
  endtask

  task automatic test_shadow();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (score_left !== 4'd3) begin errors++;
      $display("FAIL live_left got=%0d exp=3", score_left); end
    step(200, 40, 1, 0, 0, 0, 0);
    checks++;
    if (rom_digit !== 4'd0) begin errors++;
      $display("FAIL shadow_hold got=%0d exp=0", rom_digit); end
    step(200, 40, 1, 1, 0, 0, 0);
    checks++;
    if (rom_digit !== 4'd0) begin errors++;
      $display("FAIL shadow_same_cycle got=%0d exp=0", rom_digit); end
    step(200, 40, 1, 0, 0, 0, 0);
    checks += 2;
    if (rom_digit !== 4'd3) begin errors++;
      $display("FAIL shadow_update got=%0d exp=3", rom_digit); end
    if (rom_digit !== 4'(e1_d)) begin errors++;
      $display("FAIL shadow_model got=%0d exp=%0d", rom_digit, e1_d); end
  endtask

  task automatic test_game_over();
    step(0, 0, 0, 0, 1, 1, 0);
    checks++;
    if (score_left !== 4'd4 || score_right !== 4'd1) begin errors++;
      $display("FAIL both_inc got=%0d/%0d exp=4/1", score_left, score_right); end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 0);
    checks += 2;
    if (score_right !== 4'd9) begin errors++;
      $display("FAIL right_max got=%0d exp=9", score_right); end
    if (game_over !== 1'b0) begin errors++;
      $display("FAIL go_early got=%b exp=0", game_over); end
    step(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (game_over !== 1'b1) begin errors++;
      $display("FAIL go_rise got=%b exp=1", game_over); end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 0);
    checks += 2;
    if (score_left !== 4'd4 || score_right !== 4'd9) begin errors++;
      $display("FAIL go_freeze got=%0d/%0d exp=4/9", score_left, score_right); end
    if (game_over !== 1'b1) begin errors++;
      $display("FAIL go_hold got=%b exp=1", game_over); end
  endtask

  task automatic test_clear();
    step(0, 0, 0, 0, 1, 0, 1);
    checks += 2;
    if (score_left !== 4'd0 || score_right !== 4'd0) begin errors++;
      $display("FAIL clear_scores got=%0d/%0d exp=0/0", score_left, score_right); end
    if (game_over !== 1'b0) begin errors++;
      $display("FAIL clear_go got=%b exp=0", game_over); end
  endtask

  task automatic test_random();
    int x, y;
    for (int c = 0; c < 2500; c++) begin
      x = $urandom_range(180, 460);
      y = $urandom_range(20, 108);
      step(x, y, ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 299) == 0));
      checks += 8;
      if (rom_digit !== 4'(e1_d)) begin errors++;
        $display("FAIL rnd_digit c=%0d got=%0d exp=%0d", c, rom_digit, e1_d); end
      if (rom_addr !== 12'(e1_a)) begin errors++;
        $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, rom_addr, e1_a); end
      if (pix_out_valid !== 1'(e2_v)) begin errors++;
        $display("FAIL rnd_valid c=%0d got=%b exp=%0d", c, pix_out_valid, e2_v); end
      if (pix_out_hit !== 1'(e2_h)) begin errors++;
        $display("FAIL rnd_hit c=%0d got=%b exp=%0d", c, pix_out_hit, e2_h); end
      if (pix_out_rgb !== 3'(e2_rgb)) begin errors++;
        $display("FAIL rnd_rgb c=%0d got=%0d exp=%0d", c, pix_out_rgb, e2_rgb); end
      if (score_left !== 4'(m_l)) begin errors++;
        $display("FAIL rnd_left c=%0d got=%0d exp=%0d", c, score_left, m_l); end
      if (score_right !== 4'(m_r)) begin errors++;
        $display("FAIL rnd_right c=%0d got=%0d exp=%0d", c, score_right, m_r); end
      if (game_over !== 1'(m_go)) begin errors++;
        $display("FAIL rnd_go c=%0d got=%b exp=%0d", c, game_over, m_go); end
    end
  endtask

  task automatic test_mid_reset();
    step(0, 0, 0, 1, 1, 1, 0);
    step(200, 40, 1, 0, 0, 0, 0);
    step(400, 50, 1, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks += 3;
    if ({pix_out_valid, pix_out_hit, pix_out_rgb} !== 5'd0) begin errors++;
      $display("FAIL mrst_out got=%b%b%0d exp=000",
               pix_out_valid, pix_out_hit, pix_out_rgb); end
    if ({rom_digit, rom_addr} !== 16'd0) begin errors++;
      $display("FAIL mrst_rom got=%0d/%0h exp=0/0", rom_digit, rom_addr); end
    if ({score_left, score_right, game_over} !== 9'd0) begin errors++;
      $display("FAIL mrst_scores got=%0d/%0d/%b exp=0/0/0",
               score_left, score_right, game_over); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    checks++;
    if (pix_out_valid !== 1'b0) begin errors++;
      $display("FAIL mrst_rel0 got=%b exp=0", pix_out_valid); end
    step(200, 40, 1, 0, 0, 0, 0);
    checks++;
    if (pix_out_valid !== 1'b0) begin errors++;
      $display("FAIL mrst_rel1 got=%b exp=0", pix_out_valid); end
    step(200, 41, 1, 0, 0, 0, 0);
    checks += 2;
    if (pix_out_valid !== 1'(e2_v)) begin errors++;
      $display("FAIL mrst_rel2 got=%b exp=%0d", pix_out_valid, e2_v); end
    if (pix_out_rgb !== 3'(e2_rgb)) begin errors++;
      $display("FAIL mrst_rgb got=%0d exp=%0d", pix_out_rgb, e2_rgb); end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_shadow();
    test_game_over();
    test_clear();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_display_reader.md
Name: score_display_reader

Overview:
- Read-side companion to the 10-digit score image ROM (`digit` 4-bit select, 12-bit `address`, 3-bit `data`, combinational read).
- Keeps the two player scores as saturating counters and snapshots them once per frame.
- Maps the VGA pixel stream onto two 64x64 digit windows and issues ROM reads for those windows.
- Returns a pipelined 3-bit pixel colour to the pixel mux, alongside the ball and paddle layers.

Parameters:
- LEFT_X, 192, left-digit window x origin (pixels).
- RIGHT_X, 384, right-digit window x origin; must satisfy LEFT_X+64 <= RIGHT_X.
- TOP_Y, 32, y origin shared by both windows.
- MAX_SCORE, 9, saturation/win value; legal range 1..9.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous reset, active-low.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- pix_valid  in  1  pix_x/pix_y are in the active area.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- score_left_inc  in  1  one-cycle pulse: left player scored.
- score_right_inc  in  1  one-cycle pulse: right player scored.
- score_clear  in  1  one-cycle pulse: new game.
- rom_digit  out  4  digit select to the ROM.
- rom_addr  out  12  ROM address {row[5:0], col[5:0]}.
- rom_data  in  3  ROM pixel, valid in the same cycle as rom_addr.
- pix_out_valid  out  1  pix_valid delayed by 2 cycles.
- pix_out_hit  out  1  this pixel lies inside a digit window.
- pix_out_rgb  out  3  digit colour, 0 outside the windows.
- score_left  out  4  live left score.
- score_right  out  4  live right score.
- game_over  out  1  either score has reached MAX_SCORE.

Behaviour:
- Reset (rst_n=0, asynchronous): every register is 0. This covers all outputs, both live scores, both shadow scores, game_over and all pipeline stages. rom_digit=0 and rom_addr=0 during reset.
- Score counters, priority per cycle:
  - score_clear: both scores and game_over go to 0, and any same-cycle inc pulses are ignored.
  - Otherwise each inc pulse adds 1 to its own score. Left and right are independent, so simultaneous pulses both count.
  - A score equal to MAX_SCORE holds; an inc at MAX_SCORE is ignored (no wrap).
  - While game_over=1, inc pulses are ignored.
- game_over is registered. It rises in the cycle after either score reaches MAX_SCORE, and clears only on score_clear or reset.
- Shadow scores: on a frame_start cycle, shadow_left/right take the live score values present in that cycle (pre-update). They hold otherwise, so a mid-frame score change never tears the display.
- Stage 1, registered outputs, cycle N+1 for a pixel presented in cycle N:
  - Left hit when pix_valid and LEFT_X <= pix_x < LEFT_X+64 and TOP_Y <= pix_y < TOP_Y+64. Then rom_digit=shadow_left and rom_addr={(pix_y-TOP_Y)[5:0], (pix_x-LEFT_X)[5:0]}.
  - Right hit: same rule using RIGHT_X and shadow_right.
  - No hit: rom_digit=0, rom_addr=0, s1_hit=0.
  - s1_valid is pix_valid registered.
  - rom_digit is never outside 0..9.
- Stage 2, registered, cycle N+2:
  - pix_out_valid=s1_valid and pix_out_hit=s1_hit.
  - pix_out_rgb=rom_data when s1_hit, otherwise 3'b000.
  - The ROM contents are used unmodified; no colour remapping.
- Latency is fixed at 2 cycles for every pixel, hit or not. Throughput is 1 pixel/cycle with no stalls.
- Boundaries:
  - x = LEFT_X+63 is a hit and x = LEFT_X+64 is a miss; the same rule applies to y and to the right window.
  - pix_valid=0 always forces a miss, whatever the coordinates.
- frame_start and pix_valid may be high in the same cycle. The new shadow applies from the following pixel.
- Reset asserted mid-frame flushes the pipeline: pix_out_valid=0 in the first cycle after release and the cycle after that.
- Elaboration check: fatal error if windows overlap or MAX_SCORE is outside 1..9.

Decomposition:
- Shared package `pong_pkg`:
  - DIGIT_W=64, DIGIT_H=64, ROM_AW=12, PIX_W=3, COORD_W=10.
  - The digit window hit/offset function.
- One sub-module `score_counter`: a saturating 4-bit counter with inc, clear, max and at_max. Instantiated twice.
- Window mapping and the two pipeline stages stay in the top module.

Test Plan:
- Reset then pixel (192,32) valid → rom_digit=0 and rom_addr=0x000 at N+1; pix_out_hit=1 and pix_out_rgb=ROM0[0] at N+2.
- Pixel (255,95) → rom_addr=0xFFF at N+1. Pixel (256,95) → pix_out_hit=0 and pix_out_rgb=0 at N+2.
- score_left_inc ×3 mid-frame → score_left=3 immediately, rom_digit stays 0 until the next frame_start, then left-window reads use rom_digit=3.
- Both inc pulses in the same cycle → both scores +1. Drive right to 9 → game_over=1 the following cycle, and further incs leave scores at 9.
- score_clear coinciding with score_left_inc → both scores 0 and game_over=0; the inc is discarded.
- rst_n low mid-frame with valid pixels in flight → all outputs 0 asynchronously; pix_out_valid=0 for the two cycles after release.
